// File: rtl/frame_pkg.sv
// Shared constants for the frame decoder: state encoding, error codes and
// default header bytes, plus the wrapping checksum helper.
package frame_pkg;

  localparam logic [7:0] HDR0_DEFAULT = 8'hAA;
  localparam logic [7:0] HDR1_DEFAULT = 8'h55;

  // Parser state enumeration, kept as plain constants for legacy tools.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR1    = 3'd1;
  localparam logic [2:0] ST_CMD     = 3'd2;
  localparam logic [2:0] ST_LEN     = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;
  localparam logic [2:0] ST_CHK     = 3'd5;

  localparam logic [1:0] ERR_CHKSUM  = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic [7:0] chk_add(input logic [7:0] acc, input logic [7:0] data);
    return acc + data;
  endfunction

endpackage

// File: rtl/frame_parser_if.sv
// Byte-stream input, payload read port and frame status of the frame decoder.
interface frame_parser_if #(
  parameter int MAX_PAYLOAD = 32
) ();

  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [AW-1:0] payload_rd_addr;
  logic [7:0]    payload_rd_data;
  logic          parse_done;
  logic [7:0]    cmd_out;
  logic [7:0]    len_out;
  logic          parse_error;
  logic [1:0]    err_code;
  logic          busy;

  modport master (
    output rx_data, rx_valid, payload_rd_addr,
    input  payload_rd_data, parse_done, cmd_out, len_out, parse_error, err_code, busy
  );

  modport slave (
    input  rx_data, rx_valid, payload_rd_addr,
    output payload_rd_data, parse_done, cmd_out, len_out, parse_error, err_code, busy
  );

endinterface

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle timer: counts cycles while enabled, clears on each byte,
// and flags expiry while sitting at the terminal count.
module frame_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (!enable || clear) begin
      count <= '0;
    end else if (count != TERMINAL) begin
      count <= count + CW'(1);
    end
  end

  assign expired = enable && (count == TERMINAL);

endmodule

// File: rtl/frame_parser.sv
// Frame decoder: finds HDR0/HDR1, captures CMD/LEN/payload, checks the
// 8-bit wrapping checksum and reports done/error as registered pulses.
module frame_parser
  import frame_pkg::*;
#(
  parameter logic [7:0] HDR0           = HDR0_DEFAULT,
  parameter logic [7:0] HDR1           = HDR1_DEFAULT,
  parameter int         MAX_PAYLOAD    = 32,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic           clk,
  input  logic           rst_n,
  frame_parser_if.slave  bus
);

  localparam int         AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  logic [2:0] state;
  logic [7:0] chk_acc;
  logic [7:0] cmd_reg;
  logic [7:0] len_reg;
  logic [7:0] byte_cnt;
  logic       done_q;
  logic       error_q;
  logic [1:0] err_code_q;
  logic [7:0] cmd_out_q;
  logic [7:0] len_out_q;
  logic       timer_expired;
  logic [7:0] buf_mem [MAX_PAYLOAD];

  frame_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (state != ST_IDLE),
    .clear   (bus.rx_valid),
    .expired (timer_expired)
  );

  // A byte strobe always takes priority over a simultaneous timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      chk_acc    <= '0;
      cmd_reg    <= '0;
      len_reg    <= '0;
      byte_cnt   <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= '0;
      cmd_out_q  <= '0;
      len_out_q  <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (bus.rx_valid) begin
        case (state)
          ST_IDLE: begin
            if (bus.rx_data == HDR0) state <= ST_HDR1;
          end
          ST_HDR1: begin
            if (bus.rx_data == HDR1)      state <= ST_CMD;
            else if (bus.rx_data != HDR0) state <= ST_IDLE;
          end
          ST_CMD: begin
            cmd_reg <= bus.rx_data;
            chk_acc <= bus.rx_data;
            state   <= ST_LEN;
          end
          ST_LEN: begin
            len_reg  <= bus.rx_data;
            chk_acc  <= chk_add(chk_acc, bus.rx_data);
            byte_cnt <= '0;
            if (bus.rx_data > MAX_LEN) begin
              state      <= ST_IDLE;
              error_q    <= 1'b1;
              err_code_q <= ERR_LEN;
            end else if (bus.rx_data == 8'd0) begin
              state <= ST_CHK;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            chk_acc  <= chk_add(chk_acc, bus.rx_data);
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == len_reg - 8'd1) state <= ST_CHK;
          end
          ST_CHK: begin
            if (bus.rx_data == chk_acc) begin
              cmd_out_q <= cmd_reg;
              len_out_q <= len_reg;
              done_q    <= 1'b1;
            end else begin
              error_q    <= 1'b1;
              err_code_q <= ERR_CHKSUM;
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (timer_expired) begin
        state      <= ST_IDLE;
        error_q    <= 1'b1;
        err_code_q <= ERR_TIMEOUT;
      end
    end
  end

  // Payload storage carries no reset; contents are only meaningful below len_out.
  always_ff @(posedge clk) begin
    if (bus.rx_valid && (state == ST_PAYLOAD)) begin
      buf_mem[byte_cnt[AW-1:0]] <= bus.rx_data;
    end
  end

  assign bus.payload_rd_data = buf_mem[bus.payload_rd_addr];
  assign bus.parse_done      = done_q;
  assign bus.parse_error     = error_q;
  assign bus.err_code        = err_code_q;
  assign bus.cmd_out         = cmd_out_q;
  assign bus.len_out         = len_out_q;
  assign bus.busy            = (state != ST_IDLE);

endmodule

// File: tb/tb_frame_parser.sv
// Directed bench for frame_parser: good frames, checksum/length/timeout
// errors, header resync and mid-frame reset, with hand-computed expectations.
module tb_frame_parser;

  localparam int TMO = 20;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   done_cnt;
  int   err_cnt;
  int   both_cnt;
  int   done_base;
  int   err_base;
  int   wait_n;
  logic [7:0] sum;

  frame_parser_if #(.MAX_PAYLOAD(32)) bus ();

  frame_parser #(
    .MAX_PAYLOAD    (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.parse_done)                    done_cnt = done_cnt + 1;
    if (bus.parse_error)                   err_cnt  = err_cnt + 1;
    if (bus.parse_done && bus.parse_error) both_cnt = both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.payload_rd_addr = '0;
    rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_done",  32'(bus.parse_done),  32'd0);
    check_eq("rst_error", 32'(bus.parse_error), 32'd0);
    check_eq("rst_cmd",   32'(bus.cmd_out),     32'd0);
    check_eq("rst_len",   32'(bus.len_out),     32'd0);
    check_eq("rst_code",  32'(bus.err_code),    32'd0);
    check_eq("rst_busy",  32'(bus.busy),        32'd0);
    rst_n = 1'b1;
    step();

    // Heartbeat frame with empty payload
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFF); send_byte(8'h00);
    check_eq("hb_busy", 32'(bus.busy), 32'd1);
    send_byte(8'hFF);
    check_eq("hb_done",  32'(bus.parse_done),  32'd1);
    check_eq("hb_cmd",   32'(bus.cmd_out),     32'hFF);
    check_eq("hb_len",   32'(bus.len_out),     32'h00);
    check_eq("hb_error", 32'(bus.parse_error), 32'd0);
    step();
    check_eq("hb_pulse_one", 32'(bus.parse_done), 32'd0);

    // Three-byte payload, checksum 01+03+10+20+30 = 64
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h64);
    check_eq("p3_done", 32'(bus.parse_done), 32'd1);
    check_eq("p3_cmd",  32'(bus.cmd_out),    32'h01);
    check_eq("p3_len",  32'(bus.len_out),    32'h03);
    bus.payload_rd_addr = 5'd0; #1;
    check_eq("p3_pl0", 32'(bus.payload_rd_data), 32'h10);
    bus.payload_rd_addr = 5'd1; #1;
    check_eq("p3_pl1", 32'(bus.payload_rd_data), 32'h20);
    bus.payload_rd_addr = 5'd2; #1;
    check_eq("p3_pl2", 32'(bus.payload_rd_data), 32'h30);
    step();

    // Bad checksum
    done_base = done_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h30); send_byte(8'h65);
    check_eq("ck_error", 32'(bus.parse_error), 32'd1);
    check_eq("ck_code",  32'(bus.err_code),    32'd0);
    check_eq("ck_done",  32'(bus.parse_done),  32'd0);
    check_eq("ck_cmd",   32'(bus.cmd_out),     32'h01);
    check_eq("ck_len",   32'(bus.len_out),     32'h03);
    step();
    check_eq("ck_no_done", 32'(done_cnt - done_base), 32'd0);

    // Length 0x21 exceeds 32
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
    check_eq("len_busy_pre", 32'(bus.busy), 32'd1);
    send_byte(8'h21);
    check_eq("len_error", 32'(bus.parse_error), 32'd1);
    check_eq("len_code",  32'(bus.err_code),    32'd1);
    check_eq("len_busy",  32'(bus.busy),        32'd0);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'hFF); send_byte(8'h00); send_byte(8'hFF);
    check_eq("len_after_done", 32'(bus.parse_done), 32'd1);
    check_eq("len_after_cmd",  32'(bus.cmd_out),    32'hFF);
    check_eq("len_after_code", 32'(bus.err_code),   32'd1);
    step();

    // Maximum payload: 32 bytes 00..1F, checksum 04+20+F0 = 14 mod 256
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h04); send_byte(8'h20);
    sum = 8'h24;
    for (int i = 0; i < 32; i++) begin
      send_byte(8'(i));
      sum = sum + 8'(i);
    end
    check_eq("max_busy", 32'(bus.busy), 32'd1);
    send_byte(8'h14);
    check_eq("max_done", 32'(bus.parse_done), 32'd1);
    check_eq("max_len",  32'(bus.len_out),    32'h20);
    bus.payload_rd_addr = 5'd31; #1;
    check_eq("max_pl31", 32'(bus.payload_rd_data), 32'h1F);
    check_eq("max_sum_model", 32'(sum), 32'h14);
    step();

    // Header mismatch returns to IDLE silently
    err_base = err_cnt;
    send_byte(8'hAA); send_byte(8'h12);
    check_eq("hdr_busy", 32'(bus.busy), 32'd0);
    step();
    check_eq("hdr_no_err", 32'(err_cnt - err_base), 32'd0);

    // Timeout: strobe at cycle t, error pulse observed TMO cycles later
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01);
    wait_n = 0;
    while (!bus.parse_error && wait_n < 3 * TMO) begin
      step();
      wait_n = wait_n + 1;
    end
    check_eq("tmo_latency", 32'(wait_n),          32'(TMO));
    check_eq("tmo_error",   32'(bus.parse_error), 32'd1);
    check_eq("tmo_code",    32'(bus.err_code),    32'd2);
    check_eq("tmo_busy",    32'(bus.busy),        32'd0);
    step();

    // Strobe exactly at the terminal count wins over the timeout
    err_base = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01);
    repeat (TMO - 1) step();
    send_byte(8'h00);
    check_eq("tc_busy", 32'(bus.busy), 32'd1);
    send_byte(8'h01);
    check_eq("tc_done", 32'(bus.parse_done), 32'd1);
    check_eq("tc_cmd",  32'(bus.cmd_out),    32'h01);
    step();
    check_eq("tc_no_err", 32'(err_cnt - err_base), 32'd0);

    // Resync on repeated HDR0
    send_byte(8'h13); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h05);
    check_eq("rs_done", 32'(bus.parse_done), 32'd1);
    check_eq("rs_cmd",  32'(bus.cmd_out),    32'h05);
    step();

    // Reset in the middle of a payload
    done_base = done_cnt; err_base = err_cnt;
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h07); send_byte(8'h04);
    send_byte(8'h01); send_byte(8'h02);
    rst_n = 1'b0;
    #1;
    check_eq("mr_busy", 32'(bus.busy),    32'd0);
    check_eq("mr_cmd",  32'(bus.cmd_out), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check_eq("mr_no_pulse", 32'((done_cnt - done_base) + (err_cnt - err_base)), 32'd0);
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03); send_byte(8'h01);
    send_byte(8'h09); send_byte(8'h0D);
    check_eq("mr_done", 32'(bus.parse_done), 32'd1);
    check_eq("mr_cmd2", 32'(bus.cmd_out),    32'h03);
    check_eq("mr_len2", 32'(bus.len_out),    32'h01);
    bus.payload_rd_addr = 5'd0; #1;
    check_eq("mr_pl0",  32'(bus.payload_rd_data), 32'h09);
    step();

    check_eq("never_both", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/frame_parser.md
Name: frame_parser

Overview:
- Byte-stream frame decoder directly upstream of the command processor.
- Consumes bytes from the UART receiver, locates frames by a two-byte header, validates length and checksum, and presents command, length and payload.
- Signals a good frame with a one-cycle parse_done pulse, or a bad one with parse_error.

Parameters:
- HDR0, 8'hAA, first header byte
- HDR1, 8'h55, second header byte
- MAX_PAYLOAD, 32, payload buffer depth in bytes (1..255)
- TIMEOUT_CYCLES, 100000, idle clk cycles allowed between bytes inside a frame

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle
- payload_rd_addr  in  $clog2(MAX_PAYLOAD)  payload buffer read index
- payload_rd_data  out  8  payload byte at payload_rd_addr (combinational read)
- parse_done  out  1  one-cycle pulse: valid frame received
- cmd_out  out  8  command byte of last valid frame
- len_out  out  8  payload length of last valid frame
- parse_error  out  1  one-cycle pulse: frame rejected
- err_code  out  2  reason for last error: 0 checksum, 1 length overflow, 2 timeout
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset is asynchronous, active-low on rst_n; clock is clk.
- Reset values: all outputs 0, state IDLE, checksum 0, byte counter 0, timer 0.
- Frame format: HDR0, HDR1, CMD, LEN, LEN payload bytes, CHK.
- CHK = (CMD + LEN + sum of payload bytes) mod 256, accumulated in an 8-bit wrapping adder.
- Every transition occurs only on a cycle with rx_valid = 1, except the timeout transition.
- State IDLE:
  - byte == HDR0 -> HDR1.
  - Any other byte is ignored.
- State HDR1:
  - byte == HDR1 -> CMD.
  - byte == HDR0 -> stay in HDR1 (resync).
  - Otherwise -> IDLE. No error is raised.
- State CMD: latch byte into cmd register, checksum = byte -> LEN.
- State LEN:
  - byte > MAX_PAYLOAD -> IDLE with parse_error and err_code = 1.
  - byte == 0 -> CHK.
  - Otherwise -> PAYLOAD, byte counter = 0.
  - In every case, checksum += byte and the len register is latched.
- State PAYLOAD:
  - Write byte to buf[counter], checksum += byte, counter++.
  - When counter reaches len-1 on this byte -> CHK.
- State CHK, byte == checksum:
  - cmd_out and len_out are updated.
  - parse_done is asserted the next cycle (registered; one cycle after the CHK byte strobe).
  - -> IDLE.
- State CHK, byte != checksum: parse_error with err_code = 0 -> IDLE. cmd_out and len_out are unchanged.
- Timeout:
  - The timer counts cycles since the last rx_valid while state is not IDLE, and clears on every rx_valid.
  - Reaching TIMEOUT_CYCLES-1 -> IDLE with parse_error and err_code = 2.
  - rx_valid in the same cycle as the terminal count wins: the byte is processed and the timer clears.
- parse_error timing: registered, asserted the cycle after the causing event. err_code holds until the next error.
- cmd_out and len_out are stable between parse_done pulses.
- Payload buffer ownership:
  - The buffer is shared, not double-buffered. Bytes of the next frame overwrite it.
  - The consumer reads payload before the next frame's payload phase. Minimum window: 4 byte times.
- Reads at payload_rd_addr >= len_out return stale data. This is not an error.
- parse_done and parse_error are never asserted in the same cycle.
- Reset mid-frame: immediate return to IDLE, no pulse emitted. Buffer contents are don't-care.

Decomposition:
- Package frame_pkg:
  - state enum {IDLE, HDR1, CMD, LEN, PAYLOAD, CHK}
  - err code constants ERR_CHKSUM = 0, ERR_LEN = 1, ERR_TIMEOUT = 2
  - default header constants
- Sub-module frame_timeout_timer, with ports clk, rst_n, enable, clear, expired.
  - Parameterised by TIMEOUT_CYCLES.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- The FSM, checksum accumulator and payload buffer stay in frame_parser.

Test Plan:
- Send AA 55 FF 00 FF -> parse_done one cycle after the last strobe; cmd_out = FF; len_out = 00; parse_error stays 0. Confirms the command processor heartbeat path.
- Send AA 55 01 03 10 20 30 64 -> parse_done; cmd_out = 01; len_out = 03; payload_rd_data at addr 0/1/2 = 10/20/30.
- Send AA 55 01 03 10 20 30 65 -> parse_error, err_code = 0, no parse_done; cmd_out and len_out keep their prior values.
- Send AA 55 02 21 with MAX_PAYLOAD = 32 -> parse_error, err_code = 1, busy drops the following cycle. A following AA 55 FF 00 FF parses OK.
- Send AA 55 01, then no strobe for TIMEOUT_CYCLES -> parse_error, err_code = 2, busy = 0. Repeat with a strobe exactly at the terminal count -> no error.
- Send 13 AA AA 55 05 00 05 -> resync: parse_done with cmd_out = 05. Separately, assert rst_n low mid-payload -> no pulse, and a clean frame parses afterwards.
